mem_readout_uart: RTL and testbench

- Downstream consumer of the processor's data-memory readout port (parallelAddress / q).
- After the processor finishes a run, this block walks a contiguous range of data memory and serialises each 16-bit word over a UART TX line, so scalar and vector results can be captured on a host.
- It drives the address into the processor and consumes q; the link goes out on a GPIO pin.

---
 rtl/mem_readout_uart_pkg.sv | 19 +
 rtl/mem_readout_uart_if.sv | 11 +
 rtl/mem_readout_uart_tx_byte.sv | 60 ++++++
 rtl/mem_readout_uart.sv | 136 +++++++++++++
 tb/tb_mem_readout_uart.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_readout_uart_pkg.sv
// Shared types and constants for the data-memory readout UART.
package mem_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        SEND_LO,
        SEND_HI,
        NEXT,
        FINISH
    } state_t;

    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;
    localparam int unsigned BITS_PER_FRAME = 10;

endpackage

// File: rtl/mem_readout_uart_if.sv
// Processor data-memory readout port: address out, read data back.
interface mem_readout_uart_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] parallel_address;
    logic [DATA_W-1:0] q;

    modport master (output parallel_address, input q);
    modport slave  (input parallel_address, output q);
endinterface

// File: rtl/mem_readout_uart_tx_byte.sv
// 8N1 byte transmitter; a load in the last stop-bit cycle chains the next frame with no idle gap.
module uart_tx_byte
    import mem_readout_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST = 4'(BITS_PER_FRAME - 1);

    logic [CNT_W-1:0]          cnt;
    logic [3:0]                bit_idx;
    logic [BITS_PER_FRAME-1:0] shreg;
    logic                      busy_q;
    logic                      tx_q;

    assign tx_done = busy_q && (cnt == CNT_LAST) && (bit_idx == BIT_LAST);
    assign tx_busy = busy_q;
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else if (load && (!busy_q || tx_done)) begin
            shreg   <= {UART_STOP, data, UART_START};
            tx_q    <= UART_START;
            cnt     <= '0;
            bit_idx <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (bit_idx == BIT_LAST) begin
                    busy_q <= 1'b0;
                    tx_q   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx_q    <= shreg[1];
                    shreg   <= {UART_STOP, shreg[BITS_PER_FRAME-1:1]};
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_readout_uart.sv
// Walks a range of processor data memory and streams each 16-bit word over UART, low byte first.
module mem_readout_uart
    import mem_readout_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned READ_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         word_count,
    mem_readout_uart_if.master  mem,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_reg, addr_d;
    logic [ADDR_W-1:0] pa_q, pa_d;
    logic [15:0]       remaining, rem_d;
    logic [7:0]        word_hi, hi_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic [7:0]        load_data;
    logic              tx_busy;
    logic              tx_done;

    assign mem.parallel_address = pa_q;
    assign busy = busy_q;
    assign done = done_q;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data    (load_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_reg  <= '0;
            pa_q      <= '0;
            remaining <= '0;
            word_hi   <= '0;
            wait_cnt  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            addr_reg  <= addr_d;
            pa_q      <= pa_d;
            remaining <= rem_d;
            word_hi   <= hi_d;
            wait_cnt  <= wait_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The low byte is launched straight from q in CAPTURE, and the high byte in the
    // last stop-bit cycle of the low frame, so only the high byte needs holding.
    always_comb begin
        state_d   = state;
        addr_d    = addr_reg;
        pa_d      = pa_q;
        rem_d     = remaining;
        hi_d      = word_hi;
        wait_d    = wait_cnt;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_data = word_hi;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_count;
                    busy_d  = 1'b1;
                    state_d = (word_count == 16'd0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                pa_d    = addr_reg;
                wait_d  = '0;
                state_d = (READ_LAT == 0) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) state_d = CAPTURE;
                else                       wait_d  = wait_cnt + WAIT_W'(1);
            end
            CAPTURE: begin
                if (!tx_busy) begin
                    hi_d      = mem.q[15:8];
                    load      = 1'b1;
                    load_data = mem.q[7:0];
                    state_d   = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_done) begin
                    load      = 1'b1;
                    load_data = word_hi;
                    state_d   = SEND_HI;
                end
            end
            SEND_HI: begin
                if (tx_done) state_d = NEXT;
            end
            NEXT: begin
                addr_d  = addr_reg + ADDR_W'(1);
                rem_d   = remaining - 16'd1;
                state_d = (remaining == 16'd1) ? FINISH : ISSUE;
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_readout_uart.sv
// Directed bench for mem_readout_uart with a 1-cycle-latency memory model and a UART sample decoder.
module tb_mem_readout_uart;

    localparam int unsigned CPB   = 4;
    localparam int unsigned LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        tx;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem_arr [64];
    logic        txs [$];
    logic [23:0] addrs [$];
    logic [23:0] last_pa = '0;
    int          done_total = 0;

    logic [7:0]  got_b [$];
    int          starts [$];
    logic        fok [$];
    logic [15:0] exp_w [$];

    mem_readout_uart_if #(.ADDR_W(24), .DATA_W(16)) mif ();

    mem_readout_uart #(
        .ADDR_W(24), .DATA_W(16), .CLKS_PER_BIT(CPB), .READ_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem(mif), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mif.q <= mem_arr[mif.parallel_address[5:0]];

    always @(negedge clk) begin
        txs.push_back(tx);
        if (done === 1'b1) done_total++;
        if (mif.parallel_address !== last_pa) begin
            addrs.push_back(mif.parallel_address);
            last_pa = mif.parallel_address;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic decode(input int from);
        int i;
        logic [7:0] b;
        logic ok;
        logic v;
        got_b.delete(); starts.delete(); fok.delete();
        i = from;
        while (i < txs.size()) begin
            if (txs[i] == 1'b0 && i + 40 <= txs.size()) begin
                ok = 1'b1;
                b = '0;
                for (int k = 0; k < 10; k++) begin
                    v = txs[i + 4*k];
                    for (int s = 1; s < 4; s++) if (txs[i + 4*k + s] !== v) ok = 1'b0;
                    if (k == 0 && v !== 1'b0) ok = 1'b0;
                    if (k == 9 && v !== 1'b1) ok = 1'b0;
                    if (k >= 1 && k <= 8) b[k-1] = v;
                end
                got_b.push_back(b); starts.push_back(i); fok.push_back(ok);
                i += 40;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_dump(input string tag, input int from, input bit timing);
        decode(from);
        check({tag, "_nbytes"}, got_b.size(), 2 * exp_w.size());
        for (int i = 0; i < exp_w.size(); i++) begin
            if (2*i + 1 < got_b.size()) begin
                check($sformatf("%s_w%0d_lo", tag, i), got_b[2*i],   exp_w[i][7:0]);
                check($sformatf("%s_w%0d_hi", tag, i), got_b[2*i+1], exp_w[i][15:8]);
            end
        end
        for (int i = 0; i < fok.size(); i++) check($sformatf("%s_frame%0d_fmt", tag, i), fok[i], 1'b1);
        if (timing) begin
            for (int i = 0; i + 1 < starts.size(); i += 2) begin
                check($sformatf("%s_bytegap%0d", tag, i/2),
                      (starts[i+1] - starts[i] == 40) || (starts[i+1] - starts[i] == 41), 1'b1);
                if (i + 2 < starts.size())
                    check($sformatf("%s_wordgap%0d", tag, i/2), starts[i+2] - (starts[i+1] + 40), 4);
            end
        end
    endtask

    task automatic run_xfer(input logic [23:0] b, input logic [15:0] n, input int poke, output int tx_mark);
        bit seen;
        tx_mark = txs.size();
        base_addr = b; word_count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < LIMIT && !seen; c++) begin
            if (c == poke) begin
                check("busy_at_restart", busy, 1'b1);
                base_addr = 24'd4; word_count = 16'd6; start = 1'b1;
            end
            if (c == poke + 3) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        start = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int mark, amark, dmark, zeros;
        bit seen;
        foreach (mem_arr[i]) mem_arr[i] = '0;
        mem_arr[4] = 16'd5;  mem_arr[5] = 16'd7;  mem_arr[6] = 16'd13;
        mem_arr[7] = 16'd19; mem_arr[8] = 16'd23; mem_arr[9] = 16'd24;
        mem_arr[30] = 16'd7;  mem_arr[31] = 16'd11; mem_arr[32] = 16'd19;
        mem_arr[33] = 16'd26; mem_arr[34] = 16'd32; mem_arr[35] = 16'd57;
        mem_arr[63] = 16'hABCD; mem_arr[0] = 16'h1234;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", mif.parallel_address, 24'd0);
        rst = 1'b1;
        @(negedge clk);

        // basic dump
        amark = addrs.size(); dmark = done_total;
        exp_w = '{16'd5, 16'd7, 16'd13, 16'd19, 16'd23, 16'd24};
        run_xfer(24'd4, 16'd6, -1, mark);
        check_dump("basic", mark, 1'b0);
        check("basic_naddr", addrs.size() - amark, 6);
        for (int i = 0; i < 6; i++)
            if (amark + i < addrs.size()) check($sformatf("basic_addr%0d", i), addrs[amark+i], 24'(4 + i));
        check("basic_ndone", done_total - dmark, 1);
        check("basic_busy_after", busy, 1'b0);

        // vector region with bit/frame timing
        dmark = done_total;
        exp_w = '{16'd7, 16'd11, 16'd19, 16'd26, 16'd32, 16'd57};
        run_xfer(24'd30, 16'd6, -1, mark);
        check_dump("vec", mark, 1'b1);
        check("vec_ndone", done_total - dmark, 1);

        // zero count
        mark = txs.size(); amark = addrs.size();
        base_addr = 24'd123; word_count = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done_c1", done, 1'b0);
        check("zero_busy_c1", busy, 1'b1);
        @(negedge clk);
        check("zero_done_c2", done, 1'b1);
        check("zero_busy_c2", busy, 1'b0);
        @(negedge clk);
        check("zero_done_c3", done, 1'b0);
        repeat (10) @(negedge clk);
        zeros = 0;
        for (int i = mark; i < txs.size(); i++) if (txs[i] !== 1'b1) zeros++;
        check("zero_tx_low_samples", zeros, 0);
        check("zero_addr_held", mif.parallel_address, 24'd35);
        check("zero_addr_changes", addrs.size() - amark, 0);

        // address wrap with start re-asserted mid-transfer
        amark = addrs.size(); dmark = done_total;
        exp_w = '{16'hABCD, 16'h1234};
        run_xfer(24'hFFFFFF, 16'd2, 50, mark);
        check_dump("wrap", mark, 1'b0);
        check("wrap_naddr", addrs.size() - amark, 2);
        if (amark + 1 < addrs.size()) begin
            check("wrap_addr0", addrs[amark], 24'hFFFFFF);
            check("wrap_addr1", addrs[amark+1], 24'h000000);
        end
        check("wrap_ndone", done_total - dmark, 1);
        check("wrap_busy_after", busy, 1'b0);

        // reset during data bit 2 of byte 0x13 (bit value 0)
        base_addr = 24'd32; word_count = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        check("mid_start_bit_seen", seen, 1'b1);
        repeat (13) @(negedge clk);
        check("mid_pre_rst_tx", tx, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_addr", mif.parallel_address, 24'd0);
        repeat (3) @(negedge clk);
        check("mid_hold_tx", tx, 1'b1);
        check("mid_hold_busy", busy, 1'b0);
        check("mid_hold_addr", mif.parallel_address, 24'd0);
        rst = 1'b1;
        @(negedge clk);
        dmark = done_total;
        exp_w = '{16'd5};
        run_xfer(24'd4, 16'd1, -1, mark);
        check_dump("post_rst", mark, 1'b0);
        check("post_rst_ndone", done_total - dmark, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
